// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-high gfedcba patterns for digits 0-9,
// the blank pattern and the code reported for unrecognised patterns.
package seg7_pkg;

   localparam int SEG_NUM_DIGITS = 10;

   localparam logic [6:0] SEG_DIGIT [0:SEG_NUM_DIGITS-1] = '{
      7'b0111111,  // 0
      7'b0000110,  // 1
      7'b1011011,  // 2
      7'b1001111,  // 3
      7'b1100110,  // 4
      7'b1101101,  // 5
      7'b1111101,  // 6
      7'b0000111,  // 7
      7'b1111111,  // 8
      7'b1101111   // 9
   };

   localparam logic [6:0] SEG_BLANK        = 7'b0000000;
   localparam logic [3:0] SEG_INVALID_CODE = 4'hF;

   // Raw active-low bus value for an all-off display.
   localparam logic [6:0] SEG_N_IDLE = 7'h7F;

   typedef struct packed {
      logic [3:0] code;
      logic       is_blank;
      logic       is_illegal;
   } seg7_dec_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational lookup of an active-high gfedcba pattern against the shared
// digit table; anything that is neither a digit nor blank is illegal.
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] i_pattern,
   output seg7_dec_t  o_dec
);

   always_comb begin
      o_dec.code       = SEG_INVALID_CODE;
      o_dec.is_blank   = (i_pattern == SEG_BLANK);
      o_dec.is_illegal = (i_pattern != SEG_BLANK);
      for (int i = 0; i < SEG_NUM_DIGITS; i++) begin
         if (i_pattern == SEG_DIGIT[i]) begin
            o_dec.code       = 4'(i);
            o_dec.is_illegal = 1'b0;
         end
      end
   end

endmodule

// File: rtl/seg7_to_binary.sv
// Samples an asynchronous active-low segment bus, waits for each pattern to hold
// steady, and delivers each newly stable non-blank digit once via a 1-entry buffer.
module seg7_to_binary
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [6:0] seg_n,
   input  logic       ready,
   output logic [3:0] data_out,
   output logic       invalid,
   output logic       valid,
   output logic       overrun
);

   localparam int             CW      = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0]  CNT_ACC = CW'(STABLE_CYCLES - 1);

   logic [6:0]    r_sync1;
   logic [6:0]    r_sync2;
   logic [6:0]    r_prev;
   logic [CW-1:0] r_cnt;
   logic [6:0]    r_last_acc;
   logic [3:0]    r_data;
   logic          r_invalid;
   logic          r_valid;
   logic          r_overrun;

   logic [6:0]    w_p;
   logic          w_same;
   logic          w_accept;
   logic          w_new;
   logic          w_emit;
   seg7_dec_t     w_dec;

   assign w_p      = ~r_sync2;
   assign w_same   = (r_sync2 == r_prev);
   // cnt saturates at STABLE_CYCLES, so this fires exactly once per steady run.
   assign w_accept = w_same && (r_cnt == CNT_ACC);
   assign w_new    = w_accept && (w_p != r_last_acc);
   assign w_emit   = w_new && !w_dec.is_blank;

   seg7_pattern_decode u_decode (
      .i_pattern (w_p),
      .o_dec     (w_dec)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_sync1 <= SEG_N_IDLE;
         r_sync2 <= SEG_N_IDLE;
         r_prev  <= SEG_N_IDLE;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= seg_n;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         if (!w_same)
            r_cnt <= '0;
         else if (r_cnt != CNT_MAX)
            r_cnt <= r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_last_acc <= SEG_BLANK;
         r_data     <= '0;
         r_invalid  <= 1'b0;
         r_valid    <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         r_overrun <= 1'b0;
         if (w_new)
            r_last_acc <= w_p;
         if (w_emit) begin
            if (!r_valid || ready) begin
               r_data    <= w_dec.code;
               r_invalid <= w_dec.is_illegal;
               r_valid   <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign data_out = r_data;
   assign invalid  = r_invalid;
   assign valid    = r_valid;
   assign overrun  = r_overrun;

endmodule

// File: tb/tb_seg7_to_binary.sv
// Directed bench: stimulus pushes expected words into a queue, a negedge monitor
// pops and compares each word the consumer takes.
module tb_seg7_to_binary;

   logic       clk = 1'b0;
   logic       rstn;
   logic [6:0] seg_n;
   logic       ready;
   logic [3:0] data_out;
   logic       invalid;
   logic       valid;
   logic       overrun;

   int n_checks = 0;
   int n_pass   = 0;
   int n_overrun = 0;
   logic [4:0] exp_q [$];   // {invalid, data}

   // Hand-written active-high gfedcba patterns.
   localparam logic [6:0] P_BLANK = 7'b0000000;
   localparam logic [6:0] P1 = 7'b0000110;
   localparam logic [6:0] P2 = 7'b1011011;
   localparam logic [6:0] P3 = 7'b1001111;
   localparam logic [6:0] P4 = 7'b1100110;
   localparam logic [6:0] P5 = 7'b1101101;
   localparam logic [6:0] P6 = 7'b1111101;
   localparam logic [6:0] P7 = 7'b0000111;
   localparam logic [6:0] P8 = 7'b1111111;
   localparam logic [6:0] P9 = 7'b1101111;
   localparam logic [6:0] P_A = 7'b1110111;

   seg7_to_binary #(.STABLE_CYCLES(4)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .seg_n    (seg_n),
      .ready    (ready),
      .data_out (data_out),
      .invalid  (invalid),
      .valid    (valid),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else
         n_pass++;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic show(input logic [6:0] p);
      seg_n = ~p;
   endtask

   // A word is consumed on the edge following a negedge where valid && ready.
   always @(negedge clk) begin
      if (rstn && valid && ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_word", {27'd0, invalid, data_out}, 32'hDEAD);
         end else begin
            logic [4:0] e;
            e = exp_q.pop_front();
            check("word", {27'd0, invalid, data_out}, {27'd0, e});
         end
      end
      if (rstn && overrun)
         n_overrun++;
   end

   initial begin
      int ov0;
      rstn  = 1'b0;
      ready = 1'b0;
      seg_n = 7'h7F;
      tick(3);
      check("rst_valid",   {31'd0, valid},   32'd0);
      check("rst_data",    {28'd0, data_out}, 32'd0);
      check("rst_invalid", {31'd0, invalid}, 32'd0);
      check("rst_overrun", {31'd0, overrun}, 32'd0);
      #3 rstn = 1'b1;
      tick(10);
      check("idle_no_valid", {31'd0, valid}, 32'd0);

      // Latency: digit 3 set up before edge E, valid after edge E+6.
      ready = 1'b1;
      show(P3);
      exp_q.push_back({1'b0, 4'd3});
      tick(6);
      check("lat_e5_valid", {31'd0, valid}, 32'd0);
      tick(1);
      check("lat_e6_valid", {31'd0, valid}, 32'd1);
      check("lat_e6_data",  {28'd0, data_out}, 32'd3);
      tick(20);

      // 5, blank, 5 again (held long) -> two words.
      show(P5);      exp_q.push_back({1'b0, 4'd5}); tick(10);
      show(P_BLANK); tick(10);
      show(P5);      exp_q.push_back({1'b0, 4'd5}); tick(50);

      // Glitch to 8 inside steady 7 -> only one 7.
      show(P7); exp_q.push_back({1'b0, 4'd7}); tick(10);
      show(P8); tick(2);
      show(P7); tick(12);

      // Illegal pattern.
      show(P_A); exp_q.push_back({1'b1, 4'hF}); tick(10);
      show(P_BLANK); tick(10);

      // Overrun: 1 held unconsumed, 2 dropped.
      ready = 1'b0;
      ov0 = n_overrun;
      show(P1); exp_q.push_back({1'b0, 4'd1}); tick(8);
      check("ovr_valid_1", {31'd0, valid}, 32'd1);
      show(P2); tick(8);
      check("ovr_pulses", n_overrun - ov0, 32'd1);
      check("ovr_keep_valid", {31'd0, valid}, 32'd1);
      check("ovr_keep_data",  {28'd0, data_out}, 32'd1);
      ready = 1'b1;
      tick(2);
      check("ovr_drain_valid", {31'd0, valid}, 32'd0);
      check("ovr_hold_data",   {28'd0, data_out}, 32'd1);

      // Ready in the exact cycle 9 loads: no overrun, 9 replaces 4.
      ready = 1'b0;
      ov0 = n_overrun;
      show(P4); exp_q.push_back({1'b0, 4'd4}); tick(8);
      show(P9); exp_q.push_back({1'b0, 4'd9});
      tick(6);
      check("same_pre_data", {28'd0, data_out}, 32'd4);
      ready = 1'b1;
      tick(1);
      ready = 1'b0;
      check("same_valid",   {31'd0, valid},    32'd1);
      check("same_data",    {28'd0, data_out}, 32'd9);
      check("same_overrun", n_overrun - ov0,   32'd0);
      ready = 1'b1;
      tick(2);

      // Reset mid-stabilisation.
      show(P6);
      tick(3);
      rstn = 1'b0;
      #2;
      check("rst1_valid", {31'd0, valid},    32'd0);
      check("rst1_data",  {28'd0, data_out}, 32'd0);
      show(P_BLANK);
      #4 rstn = 1'b1;
      tick(10);
      check("rst1_quiet", {31'd0, valid}, 32'd0);

      // Reset while valid=1: the held word is lost.
      ready = 1'b0;
      show(P6); tick(8);
      check("rst2_pre_valid", {31'd0, valid}, 32'd1);
      rstn = 1'b0;
      #2;
      check("rst2_valid",   {31'd0, valid},    32'd0);
      check("rst2_data",    {28'd0, data_out}, 32'd0);
      check("rst2_invalid", {31'd0, invalid},  32'd0);
      show(P_BLANK);
      #4 rstn = 1'b1;
      tick(10);
      check("rst2_quiet", {31'd0, valid}, 32'd0);
      ready = 1'b1;
      show(P6); exp_q.push_back({1'b0, 4'd6}); tick(10);
      show(P_BLANK); tick(10);

      check("queue_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
